// File: rtl/mfp_pkg.sv
// Shared constants, types and elaboration-time helpers for the
// Gaussian kernel streamer: fixed-point conversion, coefficients, widths.
package mfp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_STREAM
    } strm_state_t;

    // Round half away from zero, then saturate to +/-(2^(w-1)-1).
    function automatic int to_fixed(input real v, input int fbits,
                                    input int w);
        real m;
        int  lim;
        int  r;
        m = 1.0;
        for (int i = 0; i < fbits; i++) m = m * 2.0;
        lim = (1 << (w - 1)) - 1;
        if (v >= 0.0) r = $rtoi(v * m + 0.5);
        else          r = -$rtoi(-v * m + 0.5);
        if (r > lim)  r = lim;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    // Normalised Gaussian sample at x for sigma = sig0 * step^s.
    function automatic int gauss_coef(input int s, input int x,
                                      input real sig0, input real step,
                                      input int w, input real gain);
        real sig;
        real g;
        sig = sig0;
        for (int i = 0; i < s; i++) sig = sig * step;
        g = gain * $exp(-real'(x * x) / (2.0 * sig * sig))
            / ($sqrt(2.0 * 3.14159265358979) * sig);
        return to_fixed(g, w - 1, w);
    endfunction

    function automatic int sum_w(input int w, input int half);
        return w + $clog2(2 * half + 1);
    endfunction

    function automatic int x_w(input int half);
        return $clog2(half + 1) + 1;
    endfunction

endpackage

// File: rtl/mfp_gauss_coef_rom.sv
// Constant table of the non-negative half of each kernel.
// Ports: scale, ax (|x|) in; coef out (combinational, 0 if out of range).
module mfp_gauss_coef_rom
    import mfp_pkg::*;
#(
    parameter int  OUTPUT_W   = 8,
    parameter int  HALF_LEN   = 5,
    parameter int  NUM_SCALES = 4,
    parameter real SIG0       = 1.6,
    parameter real SIG_STEP   = 1.259921,
    parameter real SCALE      = 1.0,
    parameter int  SW         = $clog2(NUM_SCALES) + 1,
    parameter int  AW         = x_w(HALF_LEN)
) (
    input  logic [SW-1:0]       scale,
    input  logic [AW-1:0]       ax,
    output logic [OUTPUT_W-1:0] coef
);

    localparam int ROW = HALF_LEN + 1;
    localparam int N   = NUM_SCALES * ROW;

    logic [OUTPUT_W-1:0] rom [N];
    int                  idx;

    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam int V = gauss_coef(i / ROW, i % ROW, SIG0, SIG_STEP,
                                      OUTPUT_W, SCALE);
        assign rom[i] = V[OUTPUT_W-1:0];
    end

    always_comb begin
        coef = '0;
        idx  = int'(scale) * ROW + int'(ax);
        for (int i = 0; i < N; i++) begin
            if (idx == i) coef = rom[i];
        end
    end

endmodule

// File: rtl/mfp_gauss_kernel_streamer.sv
// Streams one stored Gaussian kernel tap per handshake with x, markers
// and running sum. Ports: req_* request in, tap_* beat out, err pulse.
module mfp_gauss_kernel_streamer
    import mfp_pkg::*;
#(
    parameter int  OUTPUT_W   = 8,
    parameter int  HALF_LEN   = 5,
    parameter int  NUM_SCALES = 4,
    parameter real SIG0       = 1.6,
    parameter real SIG_STEP   = 1.259921,
    parameter real SCALE      = 1.0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [$clog2(NUM_SCALES):0]         req_scale,
    input  logic                                req_half,
    output logic                                tap_valid,
    input  logic                                tap_ready,
    output logic [OUTPUT_W-1:0]                 tap_data,
    output logic [x_w(HALF_LEN)-1:0]            tap_x,
    output logic                                tap_first,
    output logic                                tap_last,
    output logic [sum_w(OUTPUT_W,HALF_LEN)-1:0] tap_sum,
    output logic                                err
);

    localparam int SW = $clog2(NUM_SCALES) + 1;
    localparam int XW = x_w(HALF_LEN);
    localparam int TW = sum_w(OUTPUT_W, HALF_LEN);
    localparam int XMIN = -HALF_LEN;
    localparam logic signed [XW-1:0] X_MIN = XW'(XMIN);
    localparam logic signed [XW-1:0] X_MAX = XW'(HALF_LEN);

    strm_state_t               state_q, state_d;
    logic [SW-1:0]             scale_q, scale_d;
    logic signed [XW-1:0]      x_d;
    logic [SW-1:0]             rd_scale;
    logic signed [XW-1:0]      rd_x;
    logic [XW-1:0]             rd_ax;
    logic [OUTPUT_W-1:0]       coef;
    logic [OUTPUT_W-1:0]       data_d;
    logic [TW-1:0]             sum_d;
    logic                      first_d, last_d, err_d;

    // ROM address: the candidate start tap while idle, else the next tap.
    always_comb begin
        rd_scale = scale_q;
        rd_x     = $signed(tap_x) + XW'(1);
        if (state_q == ST_IDLE) begin
            rd_scale = req_scale;
            rd_x     = req_half ? '0 : X_MIN;
        end
        rd_ax = rd_x[XW-1] ? XW'(-rd_x) : XW'(rd_x);
    end

    mfp_gauss_coef_rom #(
        .OUTPUT_W   (OUTPUT_W),
        .HALF_LEN   (HALF_LEN),
        .NUM_SCALES (NUM_SCALES),
        .SIG0       (SIG0),
        .SIG_STEP   (SIG_STEP),
        .SCALE      (SCALE),
        .SW         (SW),
        .AW         (XW)
    ) u_rom (
        .scale (rd_scale),
        .ax    (rd_ax),
        .coef  (coef)
    );

    always_comb begin
        state_d = state_q;
        scale_d = scale_q;
        x_d     = $signed(tap_x);
        data_d  = tap_data;
        sum_d   = tap_sum;
        first_d = tap_first;
        last_d  = tap_last;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (int'(req_scale) >= NUM_SCALES) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                        scale_d = req_scale;
                        x_d     = rd_x;
                        data_d  = coef;
                        sum_d   = TW'(coef);
                        first_d = 1'b1;
                        last_d  = (rd_x == X_MAX);
                    end
                end
            end
            ST_STREAM: begin
                if (tap_ready) begin
                    first_d = 1'b0;
                    if (tap_last) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else begin
                        x_d    = rd_x;
                        data_d = coef;
                        sum_d  = tap_sum + TW'(coef);
                        last_d = (rd_x == X_MAX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scale_q   <= '0;
            req_ready <= 1'b1;
            tap_valid <= 1'b0;
            tap_data  <= '0;
            tap_x     <= '0;
            tap_sum   <= '0;
            tap_first <= 1'b0;
            tap_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            scale_q   <= scale_d;
            req_ready <= (state_d == ST_IDLE);
            tap_valid <= (state_d == ST_STREAM);
            tap_data  <= data_d;
            tap_x     <= x_d;
            tap_sum   <= sum_d;
            tap_first <= first_d;
            tap_last  <= last_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mfp_gauss_kernel_streamer.sv
// Self-checking bench for mfp_gauss_kernel_streamer: randomized requests
// and backpressure checked against a Gaussian reference model.
module tb_mfp_gauss_kernel_streamer;

    localparam int  W  = 8;
    localparam int  HL = 5;
    localparam int  NS = 4;
    localparam real S0 = 1.0;
    localparam real ST = 2.0;
    localparam int  SW = $clog2(NS) + 1;
    localparam int  XW = $clog2(HL + 1) + 1;
    localparam int  TW = W + $clog2(2 * HL + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_scale = '0;
    logic          req_half = 1'b0;
    logic          tap_valid;
    logic          tap_ready = 1'b0;
    logic [W-1:0]  tap_data;
    logic [XW-1:0] tap_x;
    logic          tap_first;
    logic          tap_last;
    logic [TW-1:0] tap_sum;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mfp_gauss_kernel_streamer #(
        .OUTPUT_W   (W),
        .HALF_LEN   (HL),
        .NUM_SCALES (NS),
        .SIG0       (S0),
        .SIG_STEP   (ST),
        .SCALE      (1.0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_scale (req_scale),
        .req_half  (req_half),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_data  (tap_data),
        .tap_x     (tap_x),
        .tap_first (tap_first),
        .tap_last  (tap_last),
        .tap_sum   (tap_sum),
        .err       (err)
    );

    // Reference: round(128 * N(x; 0, sigma)), sigma = 1.0 * 2^s, clamp 127.
    function automatic int gold(input int s, input int x);
        real sig;
        real v;
        int  r;
        sig = S0;
        for (int i = 0; i < s; i++) sig = sig * ST;
        v = 128.0 * $exp(-real'(x * x) / (2.0 * sig * sig))
            / ($sqrt(2.0 * 3.14159265358979) * sig);
        r = $rtoi(v + 0.5);
        if (r > 127) r = 127;
        return r;
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Issue a request at a negedge; returns at the negedge after acceptance.
    task automatic do_request(input int scale, input bit half);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_scale = SW'(scale);
        req_half  = half;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at the negedge just after acceptance; consumes a whole kernel
    // and returns at the negedge after the last handshake.
    task automatic collect(input int scale, input bit half, input bit rnd);
        int  exp_x, exp_n, beats, sum, g;
        bit  stalled;
        logic [W-1:0]  s_data;
        logic [XW-1:0] s_x;
        logic [TW-1:0] s_sum;
        logic          s_first, s_last;
        exp_x   = half ? 0 : -HL;
        exp_n   = half ? HL + 1 : 2 * HL + 1;
        beats   = 0;
        sum     = 0;
        stalled = 1'b0;
        n_checks++;
        if (tap_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_latency: tap_valid=%b required 1", tap_valid);
        end
        for (int cyc = 0; cyc < 400 && beats < exp_n; cyc++) begin
            if (tap_valid === 1'b1) begin
                if (stalled) begin
                    n_checks++;
                    if ({tap_data, tap_x, tap_sum, tap_first, tap_last} !==
                        {s_data, s_x, s_sum, s_first, s_last}) begin
                        n_fail++;
                        $display("FAIL stall_hold: data=%0d x=%0d sum=%0d required data=%0d x=%0d sum=%0d",
                                 tap_data, $signed(tap_x), tap_sum,
                                 s_data, $signed(s_x), s_sum);
                    end
                end
                tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tap_ready) begin
                    g = gold(scale, iabs(exp_x));
                    sum += g;
                    n_checks++;
                    if (int'($signed(tap_x)) !== exp_x) begin
                        n_fail++;
                        $display("FAIL beat_x: x=%0d required %0d",
                                 $signed(tap_x), exp_x);
                    end
                    n_checks++;
                    if (int'(tap_data) !== g) begin
                        n_fail++;
                        $display("FAIL beat_data s=%0d x=%0d: data=%0d required %0d",
                                 scale, exp_x, tap_data, g);
                    end
                    n_checks++;
                    if (int'(tap_sum) !== sum) begin
                        n_fail++;
                        $display("FAIL beat_sum x=%0d: sum=%0d required %0d",
                                 exp_x, tap_sum, sum);
                    end
                    n_checks++;
                    if (tap_first !== (beats == 0) ||
                        tap_last !== (exp_x == HL)) begin
                        n_fail++;
                        $display("FAIL beat_markers x=%0d: first=%b last=%b required %b %b",
                                 exp_x, tap_first, tap_last,
                                 beats == 0, exp_x == HL);
                    end
                    beats++;
                    exp_x++;
                    stalled = 1'b0;
                end else begin
                    {s_data, s_x, s_sum, s_first, s_last} =
                        {tap_data, tap_x, tap_sum, tap_first, tap_last};
                    stalled = 1'b1;
                end
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL valid_drop: tap_valid=%b required 1 at beat %0d",
                         tap_valid, beats);
            end
            @(negedge clk);
        end
        tap_ready = 1'b0;
        n_checks++;
        if (beats !== exp_n) begin
            n_fail++;
            $display("FAIL beat_count: beats=%0d required %0d", beats, exp_n);
        end
        n_checks++;
        if (tap_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL end_idle: tap_valid=%b req_ready=%b required 0 1",
                     tap_valid, req_ready);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks++;
        if (req_ready !== 1'b1 || tap_valid !== 1'b0 || tap_first !== 1'b0 ||
            tap_last !== 1'b0 || tap_data !== '0 || tap_x !== '0 ||
            tap_sum !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b v=%b f=%b l=%b d=%0d x=%0d s=%0d e=%b required 1 0 0 0 0 0 0 0",
                     tag, req_ready, tap_valid, tap_first, tap_last,
                     tap_data, tap_x, tap_sum, err);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_release");
    endtask

    task automatic test_full_scale0();
        int cnt;
        do_request(0, 1'b0);
        collect(0, 1'b0, 1'b0);
        do_request(0, 1'b0);
        cnt = 0;
        while (int'($signed(tap_x)) != 0 && cnt < 20) begin
            tap_ready = 1'b1;
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (tap_valid !== 1'b1 || tap_data !== 8'd51) begin
            n_fail++;
            $display("FAIL center_tap: valid=%b data=%0d required 1 51",
                     tap_valid, tap_data);
        end
        while (tap_valid === 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        tap_ready = 1'b0;
        n_checks++;
        if (tap_sum !== TW'(129)) begin
            n_fail++;
            $display("FAIL full_sum_s0: sum=%0d required 129", tap_sum);
        end
    endtask

    task automatic test_half_scale1();
        do_request(1, 1'b1);
        collect(1, 1'b1, 1'b0);
        n_checks++;
        if (tap_sum !== TW'(76)) begin
            n_fail++;
            $display("FAIL half_sum_s1: sum=%0d required 76", tap_sum);
        end
    endtask

    task automatic test_random_stall();
        for (int k = 0; k < 8; k++) begin
            int  s;
            bit  h;
            s = $urandom_range(0, NS - 1);
            h = 1'($urandom_range(0, 1));
            do_request(s, h);
            collect(s, h, 1'b1);
        end
    endtask

    task automatic test_bad_scale();
        for (int k = NS; k < NS + 2; k++) begin
            req_valid = 1'b1;
            req_scale = SW'(k);
            @(negedge clk);
            req_valid = 1'b0;
            n_checks++;
            if (err !== 1'b1 || tap_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_scale_%0d: err=%b valid=%b rdy=%b required 1 0 1",
                         k, err, tap_valid, req_ready);
            end
            @(negedge clk);
            n_checks++;
            if (err !== 1'b0 || tap_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_scale_pulse: err=%b valid=%b required 0 0",
                         err, tap_valid);
            end
        end
        do_request(2, 1'b0);
        collect(2, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_request(0, 1'b0);
        tap_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (int'($signed(tap_x)) !== -2) begin
            n_fail++;
            $display("FAIL fourth_beat_x: x=%0d required -2", $signed(tap_x));
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        rst_n     = 1'b1;
        tap_ready = 1'b0;
        @(negedge clk);
        do_request(0, 1'b0);
        collect(0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_scale = SW'(0);
        req_half  = 1'b0;
        @(negedge clk);
        req_scale = SW'(3);
        req_half  = 1'b1;
        collect(0, 1'b0, 1'b0);
        req_scale = SW'(1);
        req_half  = 1'b1;
        @(negedge clk);
        collect(1, 1'b1, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: tap_valid=%b required 0", tap_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_scale0();
        test_half_scale1();
        test_random_stall();
        test_bad_scale();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
